// File: rtl/mips_debug_pkg.sv
// Shared types and constants for the debug register-dump path.
// Holds FSM state encodings, the stream sync byte and word/byte sizing helpers.
// No logic here; imported by reg_dump_unit and word_serializer.
package mips_debug_pkg;

  // Default register width; modules derive their own sizes from NB_DATA.
  localparam int NB_DATA_DEFAULT = 32;
  localparam int BYTES_PER_WORD  = NB_DATA_DEFAULT / 8;

  // Sync byte that opens the stream when the header option is compiled in.
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // ST_HEADER keeps its encoding in every build so waveforms decode the same.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4,
    ST_HEADER  = 3'd5
  } dump_state_e;

  // Number of bytes in one register word.
  function automatic int bytes_per_word(input int nb_data);
    return nb_data / 8;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads one register word and presents it as bytes, MSB byte first.
// Latency: first byte visible the cycle after load_i; one byte per accepted transfer.
// Backpressure: byte_o and the byte count hold while send_i && !ready_i.
module word_serializer
  import mips_debug_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               send_i,
  input  logic               ready_i,
  output logic [7:0]         byte_o,
  output logic               last_o
);

  localparam int BPW   = bytes_per_word(NB_DATA);
  localparam int CNT_W = cnt_width(BPW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  logic [NB_DATA-1:0] word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer;
  logic               last_byte;

  assign xfer      = send_i && ready_i;
  assign last_byte = (cnt_q == LAST_CNT);

  // Load a fresh word, or step to the next byte after a non-final transfer.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (xfer && !last_byte) begin
      word_d = word_q << 8;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Word shift register and byte count.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_o = word_q[NB_DATA-1 -: 8];
  assign last_o = xfer && last_byte;

endmodule

// File: rtl/reg_dump_unit.sv
// Dumps every general-purpose register over a byte stream on a debug start request.
// Latency: 2 + NB_DATA/8 cycles per register with ready high; optional sync byte
// (compile with REG_DUMP_HEADER_EN) adds one cycle. Backpressure: stream stalls, address holds.
module reg_dump_unit
  import mips_debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               select_debug_o,
  output logic [NB_REG-1:0]  addr_reg_debug_o,
  input  logic [NB_DATA-1:0] data_ra_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(N_REGS - 1);

`ifdef REG_DUMP_HEADER_EN
  localparam dump_state_e START_STATE = ST_HEADER;
`else
  localparam dump_state_e START_STATE = ST_SETUP;
`endif

  dump_state_e       state_q, state_d;
  logic [NB_REG-1:0] index_q, index_d;

  logic       ser_load;
  logic       ser_send;
  logic [7:0] ser_byte;
  logic       ser_last;

  assign ser_load = (state_q == ST_CAPTURE);
  assign ser_send = (state_q == ST_SEND);

  word_serializer #(
    .NB_DATA (NB_DATA)
  ) u_word_serializer (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (ser_load),
    .word_i  (data_ra_i),
    .send_i  (ser_send),
    .ready_i (tx_ready_i),
    .byte_o  (ser_byte),
    .last_o  (ser_last)
  );

  // Sequencing: walk register indices, one SETUP/CAPTURE/SEND round per register.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          index_d = '0;
          state_d = START_STATE;
        end
      end
`ifdef REG_DUMP_HEADER_EN
      ST_HEADER: begin
        if (tx_ready_i) begin
          state_d = ST_SETUP;
        end
      end
`endif
      // Address is already stable on the bank; this cycle lets the read settle.
      ST_SETUP: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + NB_REG'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register index.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Outputs decoded from the state only, so valid never depends on ready.
  always_comb begin
    select_debug_o = 1'b0;
    tx_valid_o     = 1'b0;
    tx_data_o      = 8'h00;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
`ifdef REG_DUMP_HEADER_EN
      ST_HEADER: begin
        tx_valid_o = 1'b1;
        tx_data_o  = HEADER_BYTE;
      end
`endif
      ST_SETUP, ST_CAPTURE: begin
        select_debug_o = 1'b1;
      end
      ST_SEND: begin
        select_debug_o = 1'b1;
        tx_valid_o     = 1'b1;
        tx_data_o      = ser_byte;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  // The index register drives the bank address directly; it only moves in SETUP entry.
  assign addr_reg_debug_o = index_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
module tb_reg_dump_unit;

  localparam int NB_DATA     = 32;
  localparam int NB_REG      = 5;
  localparam int N_REGS      = 32;
  localparam int BPW         = NB_DATA / 8;
  localparam int CYC_PER_REG = 2 + BPW;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic               clock;
  logic               reset_n;
  logic               start;
  logic               sel_dbg;
  logic [NB_REG-1:0]  addr_dbg;
  logic [NB_DATA-1:0] data_ra;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               done;

  logic [NB_DATA-1:0] bank [N_REGS];

  int checks;
  int failures;
  int cyc;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int done_cnt;
  int done_cyc;
  int last_xfer;
  int first_dv;
  logic prev_valid, prev_ready, prev_sel;
  logic [7:0] prev_data;
  logic [NB_REG-1:0] prev_addr;
  logic [NB_REG+11:0] outs;
  int s;

  reg_dump_unit #(
    .NB_DATA (NB_DATA),
    .NB_REG  (NB_REG),
    .N_REGS  (N_REGS)
  ) dut (
    .clock_i          (clock),
    .reset_i          (reset_n),
    .start_i          (start),
    .select_debug_o   (sel_dbg),
    .addr_reg_debug_o (addr_dbg),
    .data_ra_i        (data_ra),
    .tx_data_o        (tx_data),
    .tx_valid_o       (tx_valid),
    .tx_ready_i       (tx_ready),
    .busy_o           (busy),
    .done_o           (done)
  );

  // Register bank: combinational read of the presented address.
  assign data_ra = bank[addr_dbg];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One cycle: drive inputs after the falling edge, observe 1 time unit later.
  // A transfer seen here happens on the next rising edge, numbered cyc.
  task automatic step(input logic rdy, input logic st, input logic rst);
    @(negedge clock);
    tx_ready = rdy;
    start    = st;
    reset_n  = rst;
    #1;
    cyc++;
    if (prev_valid && !prev_ready && reset_n) begin
      checks++;
      assert (tx_valid === 1'b1 && tx_data === prev_data)
        else begin failures++; $error("FAIL stall_hold cyc=%0d observed=%b/%h expected=1/%h", cyc, tx_valid, tx_data, prev_data); end
    end
    if (prev_valid && prev_sel && tx_valid && sel_dbg) begin
      checks++;
      assert (addr_dbg === prev_addr)
        else begin failures++; $error("FAIL addr_hold cyc=%0d observed=%0d expected=%0d", cyc, addr_dbg, prev_addr); end
    end
    if (tx_valid && sel_dbg && first_dv < 0) first_dv = cyc;
    if (tx_valid && tx_ready) begin
      got.push_back(tx_data);
      last_xfer = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_sel   = sel_dbg;
    prev_data  = tx_data;
    prev_addr  = addr_dbg;
  endtask

  task automatic fill_bank(input bit rnd);
    for (int r = 0; r < N_REGS; r++)
      bank[r] = rnd ? NB_DATA'($urandom) : NB_DATA'(32'h0101_0101 * r);
  endtask

  // Reference stream: optional sync byte, then every register MSB byte first.
  task automatic build_exp();
    exp_q.delete();
    if (HDR != 0) exp_q.push_back(8'hA5);
    for (int r = 0; r < N_REGS; r++)
      for (int b = BPW - 1; b >= 0; b--)
        exp_q.push_back(bank[r][8*b +: 8]);
  endtask

  task automatic check_outs_zero(input string tag);
    outs = {sel_dbg, addr_dbg, tx_data, tx_valid, busy, done};
    checks++;
    assert (outs === '0)
      else begin failures++; $error("FAIL %s observed=%h expected=0", tag, outs); end
  endtask

  task automatic check_stream(input string tag);
    int n;
    checks++;
    assert (got.size() === exp_q.size())
      else begin failures++; $error("FAIL %s_len observed=%0d expected=%0d", tag, got.size(), exp_q.size()); end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (got[i] === exp_q[i])
        else begin failures++; $error("FAIL %s_byte%0d observed=%h expected=%h", tag, i, got[i], exp_q[i]); end
    end
  endtask

  task automatic check_done_once(input string tag);
    checks++;
    assert (done_cnt === 1)
      else begin failures++; $error("FAIL %s_done_count observed=%0d expected=1", tag, done_cnt); end
  endtask

  task automatic check_idle_after(input string tag);
    int n;
    n = got.size();
    repeat (4) step(1'b1, 1'b0, 1'b1);
    checks++;
    assert (busy === 1'b0 && done === 1'b0 && sel_dbg === 1'b0 && got.size() === n)
      else begin failures++; $error("FAIL %s_idle observed=busy%b done%b sel%b bytes%0d expected=busy0 done0 sel0 bytes%0d", tag, busy, done, sel_dbg, got.size(), n); end
  endtask

  // mode 0: ready high; 1: stall at reg 5 byte 2 then random ready;
  // 2: start toggled during the dump; 3: reset at reg 7 byte 2.
  task automatic run_dump(input int mode, output int start_step);
    int   stall;
    bit   fin;
    logic rdy, st, rst;
    build_exp();
    got.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    last_xfer = -1;
    first_dv  = -1;
    stall     = 0;
    fin       = 0;
    step(1'b1, 1'b1, 1'b1);
    start_step = cyc;
    for (int k = 0; k < 3000 && !fin; k++) begin
      rdy = 1'b1;
      st  = 1'b0;
      rst = 1'b1;
      if (mode == 1 && got.size() >= HDR + 5*BPW + 2) begin
        if (stall < 10) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = ($urandom_range(0, 1) == 1);
        end
      end
      if (mode == 2) begin
        st  = ($urandom_range(0, 1) == 1);
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (mode == 3 && got.size() == HDR + 7*BPW + 2) rst = 1'b0;
      step(rdy, st, rst);
      if (!rst) begin
        check_outs_zero("reset_mid_dump");
        fin = 1;
      end
      if (done_cnt != 0) fin = 1;
    end
    checks++;
    assert (fin)
      else begin failures++; $error("FAIL dump_timeout mode=%0d observed=no_end expected=end", mode); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    tx_ready   = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_sel   = 1'b0;
    prev_data  = 8'h00;
    prev_addr  = '0;
    done_cnt   = 0;
    first_dv   = -1;
    fill_bank(1'b1);

    // Reset held with random inputs, then released with start low.
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
      check_outs_zero("reset_hold");
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check_outs_zero("reset_release");
    end

    // Full dump with the ramp pattern and ready tied high.
    fill_bank(1'b0);
    run_dump(0, s);
    check_stream("full");
    check_done_once("full");
    checks++;
    assert (first_dv === s + 3 + HDR)
      else begin failures++; $error("FAIL full_first_valid observed=%0d expected=%0d", first_dv - s, 3 + HDR); end
    checks++;
    assert (last_xfer === s + N_REGS*CYC_PER_REG + HDR)
      else begin failures++; $error("FAIL full_last_xfer observed=%0d expected=%0d", last_xfer - s, N_REGS*CYC_PER_REG + HDR); end
    checks++;
    assert (done_cyc === s + N_REGS*CYC_PER_REG + HDR + 1)
      else begin failures++; $error("FAIL full_done_cycle observed=%0d expected=%0d", done_cyc - s, N_REGS*CYC_PER_REG + HDR + 1); end
    check_idle_after("full");

    // Backpressure: long stall at register 5 byte 2, then random ready.
    fill_bank(1'b1);
    run_dump(1, s);
    check_stream("backpressure");
    check_done_once("backpressure");
    check_idle_after("backpressure");

    // Start toggled throughout a dump must not retrigger.
    fill_bank(1'b1);
    run_dump(2, s);
    check_stream("start_busy");
    check_done_once("start_busy");
    check_idle_after("start_busy");

    // Reset in the middle of register 7: stream abandoned, no done.
    fill_bank(1'b1);
    run_dump(3, s);
    step(1'b1, 1'b1, 1'b0);
    check_outs_zero("reset_mid_hold");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    checks++;
    assert (done_cnt === 0 && busy === 1'b0)
      else begin failures++; $error("FAIL reset_mid_no_done observed=done%0d busy%b expected=done0 busy0", done_cnt, busy); end
    checks++;
    assert (got.size() === HDR + 7*BPW + 2)
      else begin failures++; $error("FAIL reset_mid_partial observed=%0d expected=%0d", got.size(), HDR + 7*BPW + 2); end

    // Fresh dump after the abort starts again at register 0.
    fill_bank(1'b1);
    run_dump(0, s);
    check_stream("after_reset");
    check_done_once("after_reset");
    checks++;
    assert (last_xfer === s + N_REGS*CYC_PER_REG + HDR)
      else begin failures++; $error("FAIL after_reset_last_xfer observed=%0d expected=%0d", last_xfer - s, N_REGS*CYC_PER_REG + HDR); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug-side reader of the register bank. On a start request it takes over the bank's debug read port, reads all general-purpose registers in address order, and serializes each word as bytes over a valid/ready byte stream toward the UART transmitter. It sits between the debug controller and the decode stage. It drives the decode stage's debug read-port select and address, and consumes the bank's port-A read data.

## Interface
- NB_DATA, 32, register width; must be a multiple of 8
- NB_REG, 5, register address width
- N_REGS, 32, number of registers dumped (addresses 0..N_REGS-1)

- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- start_i  in  1  dump request, sampled in IDLE only; caller guarantees the pipeline is halted
- select_debug_o  out  1  selects the debug address on bank port A
- addr_reg_debug_o  out  NB_REG  register address being read
- data_ra_i  in  NB_DATA  bank port-A read data (combinational read of the presented address)
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  downstream accepts byte
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last byte transfers

## Operation
- FSM states: IDLE, SETUP, CAPTURE, SEND, DONE.
  - With the header option compiled in, HEADER is added between IDLE and SETUP.
- IDLE:
  - start_i=1 moves to SETUP, with reg index cleared to 0.
  - All other inputs are ignored.
- SETUP:
  - Drive addr_reg_debug_o = index and select_debug_o = 1.
  - Advance to CAPTURE next cycle; this cycle lets the bank read settle.
- CAPTURE:
  - Latch data_ra_i into the word shift register.
  - Clear the byte count, then go to SEND.
- SEND:
  - tx_valid_o = 1, tx_data_o = word[NB_DATA-1 -: 8], so each word goes MSB byte first.
  - Transfer occurs on a rising edge with tx_valid_o && tx_ready_i.
  - After a transfer that is not the last byte: shift word left by 8 and increment the byte count.
  - After the last byte of a word:
    - if index == N_REGS-1, go to DONE;
    - otherwise increment index and go to SETUP.
- DONE: done_o = 1 for one cycle, then return to IDLE.
- select_debug_o is high in SETUP, CAPTURE and SEND; low in IDLE, HEADER and DONE.
- Byte count and index never wrap in normal use. Index stops at N_REGS-1.

## Timing
- Reset values:
  - select_debug_o = 0, addr_reg_debug_o = 0, tx_data_o = 0
  - tx_valid_o = 0, busy_o = 0, done_o = 0
  - state = IDLE
- All outputs are registered or decoded from the state only. tx_valid_o never depends combinationally on tx_ready_i.
- While tx_valid_o = 1 and no transfer has occurred, tx_data_o is held stable.
- Per register: 2 + (NB_DATA/8) cycles minimum, i.e. 6 cycles at defaults.
- Example at defaults, with start sampled at edge E0 and tx_ready_i tied 1:
  - first tx_valid_o is high in the cycle after E2;
  - the last transfer happens at E0+192;
  - done_o is high in the cycle after E0+192.
- start_i held high through a dump does not retrigger until the FSM is back in IDLE. A new dump may start on the first edge in IDLE after DONE.
- Reset asserted mid-dump:
  - all state and outputs clear immediately;
  - the partial byte stream is abandoned, with no done_o;
  - the next start dumps from register 0.

## Configuration
- REG_DUMP_HEADER_EN defined:
  - After start, the FSM enters HEADER and sends the sync byte 0xA5 with the same handshake, then goes to SETUP.
  - Stream length is 1 + N_REGS*NB_DATA/8 bytes (129 at defaults).
  - Every SEND-phase timing figure above shifts by one cycle when ready is tied high.
- REG_DUMP_HEADER_EN undefined: there is no HEADER state, and the stream is register data only.

## Structure
- Shared package/include mips_debug_pkg holds:
  - the state encodings;
  - HEADER_BYTE = 8'hA5;
  - BYTES_PER_WORD = NB_DATA/8.
- One sub-module, word_serializer:
  - loads an NB_DATA word and emits bytes MSB first on valid/ready;
  - reports last-byte accepted.
- The top FSM owns sequencing, addressing and the done/busy signals.

## Test plan
- Reset: hold reset_i low with random inputs → all outputs are 0; release reset with start_i=0 → outputs stay 0.
- Full dump:
  - Stimulus: bank reg[i] = 32'h0101_0101*i, tx_ready_i = 1, start_i pulsed.
  - Expected stream: bytes 00 00 00 00, 01 01 01 01, …, 1F 1F 1F 1F, i.e. 128 bytes.
  - Expected done_o: one pulse, in the cycle after E0+192.
- Backpressure:
  - Stimulus: tx_ready_i low for 10 cycles at register 5, byte 2, then random toggling.
  - Expected: tx_data_o stable while stalled; no byte lost or duplicated; addr_reg_debug_o does not change during SEND.
- Start while busy: pulse start_i repeatedly during a dump → a single 128-byte stream and one done_o.
- Reset mid-dump: assert reset_i at register 7, byte 2 → all outputs clear at once and no done_o; a new start gives a full stream from register 0.
- With REG_DUMP_HEADER_EN defined: first byte is 0xA5, 129 bytes in total; register bytes match the full-dump case.
